seg_scan_ctrl: RTL and testbench

Sequencing controller for the board's 8-digit common-anode 7-segment display. It accepts a binary result from the accumulator datapath over a load/busy handshake. It converts the result to decimal with a sequential shift-add-3 engine, then time-multiplexes all eight digits with leading-zero blanking. Values too large for eight decimal digits fall back to 8-digit hex display and raise `ovf`.

---
 rtl/seg_scan_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// 8-digit common-anode 7-segment controller: sequential binary-to-BCD conversion
// over a load/busy handshake, then multiplexed scan with leading-zero blanking.
module seg_scan_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int SCAN_DIV   = 100000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] value,
    output logic                  busy,
    output logic                  ovf,
    output logic [7:0]            AN,
    output logic [7:0]            SEG
);

    localparam int              PW        = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic [5:0]      LAST_CNT  = 6'(DATA_WIDTH - 1);
    localparam logic [31:0]     DEC_MAX   = 32'd99999999;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    function automatic logic [39:0] bcd_adjust(input logic [39:0] b);
        logic [39:0] r;
        r = b;
        for (int i = 0; i < 10; i++) begin
            if (b[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = b[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = b[4*i +: 4];
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] hex_to_seg(input logic [3:0] n);
        logic [7:0] s;
        case (n)
            4'h0:    s = 8'hC0;
            4'h1:    s = 8'hF9;
            4'h2:    s = 8'hA4;
            4'h3:    s = 8'hB0;
            4'h4:    s = 8'h99;
            4'h5:    s = 8'h92;
            4'h6:    s = 8'h82;
            4'h7:    s = 8'hF8;
            4'h8:    s = 8'h80;
            4'h9:    s = 8'h98;
            4'hA:    s = 8'h88;
            4'hB:    s = 8'h83;
            4'hC:    s = 8'hC6;
            4'hD:    s = 8'hA1;
            4'hE:    s = 8'h86;
            4'hF:    s = 8'h8E;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    // Digits above the most significant nonzero digit are blanked; digit 0 never is.
    function automatic logic [7:0] blank_mask(input logic [31:0] d);
        logic [7:0] m;
        logic       nz;
        m  = 8'h00;
        nz = 1'b0;
        for (int i = 7; i >= 1; i--) begin
            if (d[4*i +: 4] != 4'd0) begin
                nz = 1'b1;
            end else begin
                nz = nz;
            end
            m[i] = ~nz;
        end
        return m;
    endfunction

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] bin_q, bin_d;
    logic [39:0]           bcd_q, bcd_d;
    logic [5:0]            cnt_q, cnt_d;
    logic [31:0]           val_q, val_d;
    logic [31:0]           dig_q, dig_d;
    logic [7:0]            blank_q, blank_d;
    logic                  ovf_q, ovf_d;
    logic                  busy_q;
    logic [PW-1:0]         presc_q, presc_d;
    logic [2:0]            idx_q, idx_d;
    logic [7:0]            an_q, an_d;
    logic [7:0]            seg_q, seg_d;

    logic [DATA_WIDTH-1:0] src_bin_s;
    logic [39:0]           src_bcd_s;
    logic [39:0]           adj_s;
    logic [DATA_WIDTH+39:0] shift_s;
    logic [39:0]           step_bcd_s;
    logic [DATA_WIDTH-1:0] step_bin_s;
    logic [31:0]           src_val_s;
    logic                  last_s;
    logic                  commit_ovf_s;
    logic                  wrap_s;

    // One shift-add-3 step; the acceptance edge performs the first step itself.
    always_comb begin
        if (state_q == CONV) begin
            src_bcd_s = bcd_q;
            src_bin_s = bin_q;
            src_val_s = val_q;
        end else begin
            src_bcd_s = 40'd0;
            src_bin_s = value;
            src_val_s = 32'(value);
        end
        adj_s        = bcd_adjust(src_bcd_s);
        shift_s      = {adj_s, src_bin_s} << 1;
        step_bcd_s   = shift_s[DATA_WIDTH+39:DATA_WIDTH];
        step_bin_s   = shift_s[DATA_WIDTH-1:0];
        commit_ovf_s = (src_val_s > DEC_MAX);
        if (state_q == CONV) begin
            last_s = (cnt_q == LAST_CNT);
        end else begin
            last_s = load && (DATA_WIDTH == 1);
        end
    end

    // Conversion FSM next state and commit of the display digits.
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        val_d   = val_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    bin_d   = step_bin_s;
                    bcd_d   = step_bcd_s;
                    cnt_d   = 6'd1;
                    val_d   = src_val_s;
                    state_d = last_s ? IDLE : CONV;
                end else begin
                    state_d = IDLE;
                end
            end
            CONV: begin
                bin_d   = step_bin_s;
                bcd_d   = step_bcd_s;
                cnt_d   = cnt_q + 6'd1;
                state_d = last_s ? IDLE : CONV;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (last_s) begin
            ovf_d = commit_ovf_s;
            if (commit_ovf_s) begin
                dig_d   = src_val_s;
                blank_d = 8'h00;
            end else begin
                dig_d   = step_bcd_s[31:0];
                blank_d = blank_mask(step_bcd_s[31:0]);
            end
        end else begin
            ovf_d   = ovf_q;
            dig_d   = dig_q;
            blank_d = blank_q;
        end
    end

    // Scan prescaler and next digit select; uses the digits held before any same-edge commit.
    always_comb begin
        wrap_s = (presc_q == PRESC_MAX);
        if (wrap_s) begin
            presc_d = PW'(0);
            idx_d   = idx_q + 3'd1;
        end else begin
            presc_d = presc_q + PW'(1);
            idx_d   = idx_q;
        end
        an_d = ~(8'd1 << idx_d);
        if (blank_q[idx_d]) begin
            seg_d = 8'hFF;
        end else begin
            seg_d = hex_to_seg(dig_q[{idx_d, 2'b00} +: 4]);
        end
    end

    // State, display and scan registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= 40'd0;
            cnt_q   <= 6'd0;
            val_q   <= 32'd0;
            dig_q   <= 32'd0;
            blank_q <= 8'hFE;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            presc_q <= '0;
            idx_q   <= 3'd0;
            an_q    <= 8'hFE;
            seg_q   <= 8'hC0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            val_q   <= val_d;
            dig_q   <= dig_d;
            blank_q <= blank_d;
            ovf_q   <= ovf_d;
            busy_q  <= (state_d == CONV);
            presc_q <= presc_d;
            idx_q   <= idx_d;
            if (wrap_s) begin
                an_q  <= an_d;
                seg_q <= seg_d;
            end else begin
                an_q  <= an_q;
                seg_q <= seg_q;
            end
        end
    end

    assign busy = busy_q;
    assign ovf  = ovf_q;
    assign AN   = an_q;
    assign SEG  = seg_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: cycle-accurate behavioural model plus
// directed scenarios with hand-computed segment patterns.
module tb_seg_scan_ctrl;

    localparam int DW = 32;
    localparam int SD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          load;
    logic [DW-1:0] value;
    logic          busy;
    logic          ovf;
    logic [7:0]    AN;
    logic [7:0]    SEG;

    int checks = 0;
    int errors = 0;

    seg_scan_ctrl #(.DATA_WIDTH(DW), .SCAN_DIV(SD)) dut (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .value (value),
        .busy  (busy),
        .ovf   (ovf),
        .AN    (AN),
        .SEG   (SEG)
    );

    always #5 clk = ~clk;

    logic [7:0] segtab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h98, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // Model state
    bit          m_valid = 1'b0;
    int          k;
    bit          m_busy;
    int          m_rem;
    logic [31:0] m_lat;
    bit          m_ovf;
    logic [7:0]  m_seg [8];
    logic [7:0]  exp_an;
    logic [7:0]  exp_seg;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // What each digit position should show for a committed value.
    task automatic set_display(input logic [31:0] v);
        longint lv;
        longint pw;
        lv = longint'(v);
        if (lv > 64'd99999999) begin
            m_ovf = 1'b1;
            for (int i = 0; i < 8; i++) m_seg[i] = segtab[(lv >> (4 * i)) & 15];
        end else begin
            m_ovf = 1'b0;
            pw = 1;
            for (int i = 0; i < 8; i++) begin
                if (i > 0 && lv < pw) m_seg[i] = 8'hFF;
                else                  m_seg[i] = segtab[(lv / pw) % 10];
                pw = pw * 10;
            end
        end
    endtask

    // Model: k counts edges since reset; the slot changes every SD edges and
    // latches the digits that were committed before that edge.
    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1'b1;
            k       = 0;
            m_busy  = 1'b0;
            m_rem   = 0;
            set_display(32'd0);
            exp_an  = 8'hFE;
            exp_seg = m_seg[0];
        end else if (m_valid) begin
            k++;
            if (k % SD == 0) begin
                exp_an  = ~(8'd1 << ((k / SD) % 8));
                exp_seg = m_seg[(k / SD) % 8];
            end
            if (m_busy) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_busy = 1'b0;
                    set_display(m_lat);
                end
            end else if (load) begin
                m_lat = 32'(value);
                if (DW == 1) set_display(m_lat);
                else begin
                    m_busy = 1'b1;
                    m_rem  = DW - 1;
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("busy", {7'd0, busy}, {7'd0, m_busy});
            chk("ovf",  {7'd0, ovf},  {7'd0, m_ovf});
            chk("AN",   AN,  exp_an);
            chk("SEG",  SEG, exp_seg);
        end
    end

    logic [7:0] seen [8];

    task automatic do_load(input logic [DW-1:0] v);
        @(posedge clk); #1;
        load  = 1'b1;
        value = v;
        @(posedge clk); #1;
        load  = 1'b0;
        value = 32'hDEADBEEF;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (busy) n++;
            else if (n > 0) break;
        end
        chk("idle_reached", {7'd0, busy}, 8'd0);
    endtask

    task automatic capture();
        for (int i = 0; i < 8; i++) seen[i] = 8'h00;
        repeat (40) begin
            @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                if (AN == ~(8'd1 << i)) seen[i] = SEG;
            end
        end
    endtask

    initial begin
        int n;
        logic [7:0] exp_hex [8];
        rst   = 1'b1;
        load  = 1'b0;
        value = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_AN", AN, 8'hFE);
        chk("rst_SEG", SEG, 8'hC0);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_ovf", {7'd0, ovf}, 8'd0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("scan1_AN", AN, 8'hFD);
        chk("scan1_SEG", SEG, 8'hFF);
        repeat (28) @(posedge clk);
        @(negedge clk);
        chk("scan_wrap_AN", AN, 8'hFE);
        chk("scan_wrap_SEG", SEG, 8'hC0);

        do_load(32'd12345678);
        wait_idle(n);
        chk("busy_len", 8'(n), 8'd31);
        capture();
        chk("d12345678_0", seen[0], 8'h80);
        chk("d12345678_7", seen[7], 8'hF9);
        chk("d12345678_4", seen[4], 8'h99);
        chk("ovf_12345678", {7'd0, ovf}, 8'd0);

        do_load(32'd1005);
        wait_idle(n);
        capture();
        chk("d1005_3", seen[3], 8'hF9);
        chk("d1005_2", seen[2], 8'hC0);
        chk("d1005_1", seen[1], 8'hC0);
        chk("d1005_0", seen[0], 8'h92);
        for (int i = 4; i < 8; i++) chk("d1005_blank", seen[i], 8'hFF);

        do_load(32'h05F5E100);
        wait_idle(n);
        capture();
        chk("hex_ovf", {7'd0, ovf}, 8'd1);
        exp_hex = '{8'hC0, 8'hC0, 8'hF9, 8'h86, 8'h92, 8'h8E, 8'h92, 8'hC0};
        for (int i = 0; i < 8; i++) chk("hex_digit", seen[i], exp_hex[i]);

        do_load(32'd42);
        repeat (4) @(posedge clk);
        #1 load = 1'b1; value = 32'd7;
        @(posedge clk); #1 load = 1'b0; value = 32'd0;
        wait_idle(n);
        capture();
        chk("d42_1", seen[1], 8'h99);
        chk("d42_0", seen[0], 8'hA4);
        chk("d42_2", seen[2], 8'hFF);
        chk("ovf_42", {7'd0, ovf}, 8'd0);
        do_load(32'd7);
        wait_idle(n);
        capture();
        chk("d7_0", seen[0], 8'hF8);
        chk("d7_1", seen[1], 8'hFF);

        // load held high: back-to-back reloads with a changing value
        @(posedge clk); #1 load = 1'b1;
        for (int c = 0; c < 70; c++) begin
            value = 32'(c * 1234567 + 3);
            @(posedge clk); #1;
        end
        load = 1'b0;
        wait_idle(n);
        capture();

        do_load(32'd999);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", {7'd0, busy}, 8'd0);
        repeat (40) @(posedge clk);
        capture();
        chk("abort_d0", seen[0], 8'hC0);
        chk("abort_d1", seen[1], 8'hFF);
        chk("abort_d2", seen[2], 8'hFF);
        chk("abort_ovf", {7'd0, ovf}, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
